// File: rtl/result_writer.sv
// Result writer: 4-entry FIFO that gathers engine results for one batch,
// then drains them in write order to a valid/ready consumer.
// Ports:
//   clk, rst (async, active-low)
//   wr_req/wr_data        upstream results
//   done                  end-of-batch pulse
//   out_valid/out_ready   downstream handshake
//   out_data/out_last     oldest word, final-word flag
//   batch_done            one-cycle drain-complete pulse
//   count/full/empty      occupancy
//   overflow              sticky dropped-write flag
module result_writer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_req,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             done,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             batch_done,
  output logic [2:0]       count,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    FIN     = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       wr_ptr_q, wr_ptr_d;
  logic [1:0]       rd_ptr_q, rd_ptr_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic wr_en;
  logic drop;
  logic hs;

  assign count = cnt_q;
  assign full  = (cnt_q == 3'd4);
  assign empty = (cnt_q == 3'd0);
  assign overflow = ovf_q;
  assign out_data = mem_q[rd_ptr_q];

  assign wr_en = (state_q == COLLECT) && wr_req && !full;
  assign drop  = wr_req && !wr_en;
  assign hs    = out_valid && out_ready;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= COLLECT;
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      cnt_q    <= 3'd0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is left unreset; out_data is ignored while out_valid=0.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (wr_en) begin
      mem_d[wr_ptr_q] = wr_data;
    end
  end

  // Pointers, occupancy and sticky overflow.
  // wr_en (COLLECT) and hs (DRAIN) are mutually exclusive.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q | drop;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 2'd1;
      cnt_d    = cnt_q + 3'd1;
    end
    if (hs) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
      cnt_d    = cnt_q - 3'd1;
    end
  end

  // Next-state logic. A write coinciding with done joins the batch,
  // so an empty FIFO plus a same-cycle write still drains.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      COLLECT: begin
        if (done) begin
          if (!empty || wr_en) state_d = DRAIN;
          else                 state_d = FIN;
        end
      end
      DRAIN: begin
        if (hs && out_last) state_d = FIN;
      end
      FIN: state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // Output logic
  always_comb begin
    out_valid  = 1'b0;
    out_last   = 1'b0;
    batch_done = 1'b0;
    unique case (state_q)
      COLLECT: ;
      DRAIN: begin
        out_valid = !empty;
        out_last  = (cnt_q == 3'd1);
      end
      FIN: batch_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_result_writer.sv
// Directed testbench for result_writer.
// Immediate assertions at each check point, linear stimulus.
module tb_result_writer;

  logic        clk;
  logic        rst;
  logic        wr_req;
  logic [15:0] wr_data;
  logic        done;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_last;
  logic        batch_done;
  logic [2:0]  count;
  logic        full;
  logic        empty;
  logic        overflow;

  int checks;
  int errors;

  result_writer #(.WIDTH(16), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_req    (wr_req),
    .wr_data   (wr_data),
    .done      (done),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .batch_done(batch_done),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input logic [15:0] d);
    wr_req  = 1'b1;
    wr_data = d;
    tick();
    wr_req  = 1'b0;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    check("collect_no_valid", {31'd0, out_valid}, 32'd0);
    tick();
    done = 1'b0;
  endtask

  // Drain four words with out_ready held high, then check FIN.
  task automatic drain4(input string tag,
                        input logic [15:0] w0,
                        input logic [15:0] w1,
                        input logic [15:0] w2,
                        input logic [15:0] w3);
    logic [15:0] exp [4];
    exp[0] = w0; exp[1] = w1; exp[2] = w2; exp[3] = w3;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_data"}, {16'd0, out_data}, {16'd0, exp[k]});
      check({tag, "_last"}, {31'd0, out_last}, (k == 3) ? 32'd1 : 32'd0);
      check({tag, "_count"}, {29'd0, count}, 32'(4 - k));
      tick();
    end
    out_ready = 1'b0;
    check({tag, "_bdone"}, {31'd0, batch_done}, 32'd1);
    check({tag, "_fin_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_fin_empty"}, {31'd0, empty}, 32'd1);
    tick();
    check({tag, "_bdone_low"}, {31'd0, batch_done}, 32'd0);
  endtask

  initial begin
    logic [15:0] bp [4];
    int idx;

    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    wr_req    = 1'b0;
    wr_data   = '0;
    done      = 1'b0;
    out_ready = 1'b0;

    // Reset state
    #3;
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_last", {31'd0, out_last}, 32'd0);
    check("rst_bdone", {31'd0, batch_done}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Nominal batch
    write_word(16'h0011);
    check("nom_count1", {29'd0, count}, 32'd1);
    write_word(16'h0022);
    write_word(16'h0033);
    write_word(16'h0044);
    check("nom_count4", {29'd0, count}, 32'd4);
    check("nom_full", {31'd0, full}, 32'd1);
    pulse_done();
    drain4("nom", 16'h0011, 16'h0022, 16'h0033, 16'h0044);
    check("nom_ovf", {31'd0, overflow}, 32'd0);

    // Backpressure: out_ready toggles 0/1 each cycle
    bp[0] = 16'h0011; bp[1] = 16'h0022;
    bp[2] = 16'h0033; bp[3] = 16'h0044;
    for (int i = 0; i < 4; i++) write_word(bp[i]);
    pulse_done();
    idx = 0;
    for (int cyc = 0; cyc < 20 && idx < 4; cyc++) begin
      out_ready = cyc[0];
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_data", {16'd0, out_data}, {16'd0, bp[idx]});
      check("bp_last", {31'd0, out_last}, (idx == 3) ? 32'd1 : 32'd0);
      check("bp_count", {29'd0, count}, 32'(4 - idx));
      tick();
      if (out_ready) idx++;
    end
    out_ready = 1'b0;
    check("bp_all_drained", idx, 32'd4);
    check("bp_bdone", {31'd0, batch_done}, 32'd1);
    tick();

    // Empty batch
    done = 1'b1;
    tick();
    done = 1'b0;
    check("emp_bdone", {31'd0, batch_done}, 32'd1);
    check("emp_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("emp_bdone_low", {31'd0, batch_done}, 32'd0);
    check("emp_valid2", {31'd0, out_valid}, 32'd0);
    check("emp_ovf", {31'd0, overflow}, 32'd0);

    // Write attempted during drain
    write_word(16'h0011);
    write_word(16'h0022);
    write_word(16'h0033);
    write_word(16'h0044);
    pulse_done();
    out_ready = 1'b1;
    wr_req    = 1'b1;
    wr_data   = 16'h00AA;
    check("wid_d0", {16'd0, out_data}, 32'h0011);
    tick();
    wr_req = 1'b0;
    check("wid_ovf", {31'd0, overflow}, 32'd1);
    check("wid_d1", {16'd0, out_data}, 32'h0022);
    check("wid_count", {29'd0, count}, 32'd3);
    tick();
    check("wid_d2", {16'd0, out_data}, 32'h0033);
    tick();
    check("wid_d3", {16'd0, out_data}, 32'h0044);
    check("wid_last", {31'd0, out_last}, 32'd1);
    tick();
    out_ready = 1'b0;
    check("wid_bdone", {31'd0, batch_done}, 32'd1);
    check("wid_empty", {31'd0, empty}, 32'd1);
    tick();

    // Clear overflow via reset
    rst = 1'b0;
    #1;
    check("rst2_ovf", {31'd0, overflow}, 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // Overflow: fifth write dropped
    write_word(16'h0001);
    write_word(16'h0002);
    write_word(16'h0003);
    write_word(16'h0004);
    check("ovf_pre", {31'd0, overflow}, 32'd0);
    write_word(16'h0005);
    check("ovf_set", {31'd0, overflow}, 32'd1);
    check("ovf_count", {29'd0, count}, 32'd4);
    pulse_done();
    drain4("ovf", 16'h0001, 16'h0002, 16'h0003, 16'h0004);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Reset mid-drain
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    write_word(16'h1111);
    write_word(16'h2222);
    write_word(16'h3333);
    write_word(16'h4444);
    pulse_done();
    out_ready = 1'b1;
    tick();
    tick();
    check("rmd_count2", {29'd0, count}, 32'd2);
    #2;
    rst = 1'b0;
    #1;
    check("rmd_count", {29'd0, count}, 32'd0);
    check("rmd_empty", {31'd0, empty}, 32'd1);
    check("rmd_valid", {31'd0, out_valid}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    check("rmd_post_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("rmd_post_valid2", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;
    write_word(16'h0101);
    write_word(16'h0202);
    write_word(16'h0303);
    write_word(16'h0404);
    pulse_done();
    drain4("rmd", 16'h0101, 16'h0202, 16'h0303, 16'h0404);

    // Write together with done on an empty FIFO joins the batch
    wr_req  = 1'b1;
    wr_data = 16'h0BEE;
    done    = 1'b1;
    tick();
    wr_req = 1'b0;
    done   = 1'b0;
    check("wd_valid", {31'd0, out_valid}, 32'd1);
    check("wd_data", {16'd0, out_data}, 32'h0BEE);
    check("wd_last", {31'd0, out_last}, 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("wd_bdone", {31'd0, batch_done}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/result_writer.md
RESULT_WRITER -- requirements
Module: result_writer

Interface
REQ-001 Parameter: WIDTH, 16, bit width of one engine result word.
REQ-002 Parameter: DEPTH, 4, number of FIFO entries; fixed at 4, one entry per controller iteration.
REQ-003 Port: clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-low reset; rst=0 forces the reset state immediately, independent of clk.
REQ-005 Port: wr_req  input  1  write strobe from the upstream controller, one cycle per result.
REQ-006 Port: wr_data  input  WIDTH  engine result, valid while wr_req=1.
REQ-007 Port: done  input  1  end-of-batch pulse from the upstream controller.
REQ-008 Port: out_ready  input  1  downstream consumer can accept a word this cycle.
REQ-009 Port: out_valid  output  1  out_data holds a valid word.
REQ-010 Port: out_data  output  WIDTH  oldest stored result.
REQ-011 Port: out_last  output  1  the current out_data is the final word of the batch.
REQ-012 Port: batch_done  output  1  one-cycle pulse: batch fully drained.
REQ-013 Port: count  output  3  number of occupied entries, 0..4.
REQ-014 Port: full  output  1  count==4.
REQ-015 Port: empty  output  1  count==0.
REQ-016 Port: overflow  output  1  sticky flag: a write was dropped.

Function
REQ-017 The block SHALL implement a 4-entry circular FIFO with 2-bit read and write pointers that wrap 3->0, plus a 3-bit occupancy counter.
REQ-018 The FSM SHALL have three states: COLLECT, DRAIN and FIN.
- COLLECT: accepts writes; out_valid=0.
- DRAIN: drives out_valid=!empty.
- FIN: drives batch_done=1 for exactly one cycle.
REQ-019 In COLLECT, wr_req=1 with full=0 SHALL store wr_data at the write pointer, advance the pointer and increment count.
REQ-020 In COLLECT, wr_req=1 with full=1 SHALL drop the word, leave FIFO contents unchanged and set overflow.
REQ-021 A wr_req in DRAIN or FIN SHALL be dropped and SHALL set overflow.
REQ-022 Transitions out of COLLECT on a sampled done=1:
- count>0: go to DRAIN; out_valid rises the cycle after done is sampled.
- count==0: go directly to FIN.
REQ-023 If wr_req and done are both 1 in the same COLLECT cycle, the write SHALL be accepted (subject to REQ-020) before the transition, and that word is included in the batch.
REQ-024 In DRAIN, a handshake is out_valid=1 and out_ready=1; each handshake SHALL advance the read pointer and decrement count.
REQ-025 out_data SHALL equal the entry at the read pointer and SHALL stay stable while out_valid=1 and out_ready=0.
REQ-026 out_last SHALL be 1 exactly when state is DRAIN and count==1.
REQ-027 A handshake with out_last=1 SHALL move the FSM to FIN on the next edge; FIN SHALL always return to COLLECT after one cycle.
REQ-028 done pulses received in DRAIN or FIN SHALL be ignored.
REQ-029 Words SHALL leave in exact write order; maximum throughput is one word per cycle.
REQ-030 full, empty and count SHALL be derived combinationally from the occupancy counter; count SHALL never exceed 4 or underflow below 0.
REQ-031 overflow SHALL stay 1 until reset.

Reset
REQ-032 While rst=0, the block SHALL hold:
- state=COLLECT;
- read and write pointers=0, count=0;
- overflow=0, out_valid=0, out_last=0, batch_done=0;
- full=0, empty=1.
REQ-033 Storage array contents need not be reset; out_data is don't-care while out_valid=0.
REQ-034 An assertion of rst mid-DRAIN SHALL discard all stored words; after release, no out_valid until a new batch completes.

Verification
REQ-035 Nominal batch: write 0x0011, 0x0022, 0x0033, 0x0044, then done, out_ready=1 -> out_data 0x0011..0x0044 on 4 consecutive cycles; out_last=1 only with 0x0044; batch_done=1 on the following cycle.
REQ-036 Backpressure: same batch with out_ready toggling 0/1 each cycle -> each word held stable while out_ready=0; order and out_last unchanged; count decrements only on handshakes.
REQ-037 Overflow: 5 writes 0x0001..0x0005 in COLLECT, then done -> 0x0005 dropped, overflow=1 and sticky; drain yields 0x0001..0x0004.
REQ-038 Empty batch: done with count==0 -> out_valid stays 0; batch_done=1 one cycle after done is sampled.
REQ-039 Write in DRAIN: wr_req with 0x00AA during drain -> word dropped, overflow=1, drained sequence unchanged.
REQ-040 Reset mid-drain: rst=0 after 2 of 4 words drained -> count=0, empty=1, out_valid=0 immediately; next batch of 4 drains correctly from pointer 0.
